// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, ALU opcode and the multiply
// sequencer state, plus the sequencer's next-state decode helper.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } mulstate_t;

    // Where the sequencer goes once the remaining multiplier bits are known.
    function automatic mulstate_t mul_next_state(input word_t mplier);
        mulstate_t nxt;
        if (mplier == {WORD_W{1'b0}}) begin
            nxt = DONE;
        end else if (mplier[0]) begin
            nxt = ADD;
        end else begin
            nxt = SHIFT;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier that borrows the shared execute-stage ALU; the
// execute-stage request passes through whenever the sequencer is not working.
module alu_mul_sequencer
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [WORD_W-1:0] mul_a,
    input  logic [WORD_W-1:0] mul_b,
    output logic              busy,
    output logic              done,
    output logic [WORD_W-1:0] result,
    input  aluop_t            ex_aluop,
    input  logic [WORD_W-1:0] ex_porta,
    input  logic [WORD_W-1:0] ex_portb,
    output logic [WORD_W-1:0] ex_out,
    output aluop_t            alu_op,
    output logic [WORD_W-1:0] alu_porta,
    output logic [WORD_W-1:0] alu_portb,
    input  logic [WORD_W-1:0] alu_out
);

    mulstate_t         r_state;
    mulstate_t         w_next_state;
    logic [WORD_W-1:0] r_acc;
    logic [WORD_W-1:0] r_mcand;
    logic [WORD_W-1:0] r_mplier;
    logic [WORD_W-1:0] r_result;
    logic [WORD_W-1:0] w_mplier_shr;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start is only honoured from IDLE.
    always_comb begin
        w_next_state = r_state;
        w_mplier_shr = r_mplier >> 1;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = mul_next_state(mul_b);
                end else begin
                    w_next_state = IDLE;
                end
            end
            ADD:     w_next_state = SHIFT;
            SHIFT:   w_next_state = mul_next_state(w_mplier_shr);
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Multiply datapath; result only changes when DONE is entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_acc    <= {WORD_W{1'b0}};
            r_mcand  <= {WORD_W{1'b0}};
            r_mplier <= {WORD_W{1'b0}};
            r_result <= {WORD_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_acc    <= {WORD_W{1'b0}};
                        r_mcand  <= mul_a;
                        r_mplier <= mul_b;
                        if (mul_b == {WORD_W{1'b0}}) begin
                            r_result <= {WORD_W{1'b0}};
                        end
                    end
                end
                ADD: begin
                    r_acc <= alu_out;
                end
                SHIFT: begin
                    r_mcand  <= alu_out;
                    r_mplier <= w_mplier_shr;
                    if (w_mplier_shr == {WORD_W{1'b0}}) begin
                        r_result <= r_acc;
                    end
                end
                DONE: begin
                    r_acc <= r_acc;
                end
                default: begin
                    r_acc <= r_acc;
                end
            endcase
        end
    end

    // ALU ownership mux: the sequencer drives the ALU only in ADD/SHIFT.
    always_comb begin
        alu_op    = ex_aluop;
        alu_porta = ex_porta;
        alu_portb = ex_portb;
        case (r_state)
            ADD: begin
                alu_op    = ALU_ADD;
                alu_porta = r_acc;
                alu_portb = r_mcand;
            end
            SHIFT: begin
                alu_op    = ALU_SLL;
                alu_porta = r_mcand;
                alu_portb = {{(WORD_W-1){1'b0}}, 1'b1};
            end
            default: begin
                alu_op    = ex_aluop;
                alu_porta = ex_porta;
                alu_portb = ex_portb;
            end
        endcase
    end

    assign busy   = (r_state == ADD) || (r_state == SHIFT);
    assign done   = (r_state == DONE);
    assign result = r_result;
    assign ex_out = alu_out;

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle shift-add multiplier controller that reuses the shared ALU instead of adding a dedicated multiplier array.
- Sits beside the execute stage and owns the ALU mux.
- Idle: the execute stage's ALU request passes straight through.
- Busy: the block takes the ALU, sequences ALU_ADD/ALU_SLL operations, and stalls the pipeline until the 32-bit low product is ready.

Parameters:
- WORD_W, 32, datapath width; must match word_t.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  reset, synchronous, active-high.
- start  in  1  request a multiply; sampled only in IDLE.
- mul_a  in  WORD_W  multiplicand, captured on accepted start.
- mul_b  in  WORD_W  multiplier, captured on accepted start.
- busy  out  1  high in ADD/SHIFT; pipeline stall request.
- done  out  1  one-cycle pulse, product valid.
- result  out  WORD_W  registered product, low 32 bits; held until next accepted start.
- ex_aluop  in  aluop_t  execute-stage ALU op.
- ex_porta  in  WORD_W  execute-stage operand A.
- ex_portb  in  WORD_W  execute-stage operand B.
- ex_out  out  WORD_W  ALU result returned to execute; equals alu_out every cycle.
- alu_op  out  aluop_t  to shared ALU ALUOP.
- alu_porta  out  WORD_W  to ALU PortA.
- alu_portb  out  WORD_W  to ALU PortB.
- alu_out  in  WORD_W  from ALU OutputPort.

Behaviour:
- Clocking and reset:
  - One clock, CLK.
  - RST is synchronous, active-high. When it is high at a rising edge: state=IDLE, acc=0, mcand=0, mplier=0, result=0, busy=0, done=0.
  - Reset mid-operation abandons the multiply. No done pulse is produced for it.
- States: IDLE, ADD, SHIFT, DONE (enum mulstate_t).
- IDLE:
  - start=1 captures mcand<=mul_a, mplier<=mul_b, acc<=0.
  - Next state: DONE if mul_b==0; ADD if mul_b[0]; otherwise SHIFT.
  - start=0 stays in IDLE.
- ADD:
  - Drive alu_op=ALU_ADD, porta=acc, portb=mcand.
  - acc<=alu_out; next state SHIFT.
- SHIFT:
  - Drive alu_op=ALU_SLL, porta=mcand, portb=1.
  - mcand<=alu_out; mplier<=mplier>>1 (logical).
  - Let m' = mplier>>1. Next state: DONE if m'==0; ADD if m'[0]; otherwise SHIFT.
- DONE:
  - result<=acc on entry; result is registered and visible while done=1.
  - done=1 for exactly this cycle; next state IDLE.
  - start during DONE is ignored.
- Latency:
  - m = index of highest set bit of mul_b; k = popcount(mul_b).
  - Work cycles = (m+1)+k. Minimum 2 (b=1); maximum 64 (b=0xFFFFFFFF).
  - With start accepted at edge t, done=1 in cycle t+(m+1)+k+1.
  - b==0 gives done in cycle t+1 with result=0.
- Arithmetic:
  - All adds wrap mod 2^32; ALU Overflow/flags are ignored.
  - The low 32 bits of the product are identical for signed and unsigned operands.
- ALU mux (combinational):
  - state in {ADD,SHIFT}: alu_* driven by the sequencer; ex_* ignored.
  - Otherwise (IDLE, DONE, including the start cycle): alu_*=ex_*.
- busy is a combinational decode of state (ADD or SHIFT). No glitch-sensitive logic is allowed downstream.
- start while busy: ignored, no queuing.

Decomposition:
- cpu_types_pkg: aluop_t and word_t already exist and are reused; add mulstate_t there.
- No sub-module. The ALU stays instantiated in the parent and is connected through the alu_* ports.

Test Plan:
- Reset: RST=1 two cycles -> busy=0, done=0, result=0; ex_aluop=ALU_OR, 0xF0|0x0F passes to alu_* and ex_out=0xFF.
- a=3, b=5, start at t -> alu_op sequence ADD,SHIFT,SHIFT,ADD,SHIFT in t+1..t+5; done=1 and result=15 at t+6; busy=0 at t+6.
- a=0xFFFFFFFE (-2), b=3 -> result=0xFFFFFFFA after 4 work cycles; a=0x12345678, b=0 -> done at t+1, result=0.
- a=1, b=0xFFFFFFFF -> 64 busy cycles, result=0xFFFFFFFF; start pulsed mid-operation is ignored, single done pulse.
- Mux check: during busy, drive ex_aluop=ALU_XOR with random operands -> alu_op only ADD/SLL; in DONE cycle alu_op==ex_aluop.
- RST asserted in 3rd busy cycle of 7*9 -> next cycle IDLE, busy=0, no done; new start 4*4 -> result=16.
